// File: rtl/bcd_a_binario.sv
// Sequential packed-BCD to unsigned binary converter, one digit per clock, MSD first.
// Start/done handshake: iniciar starts a conversion, terminado pulses once with the result.
module bcd_a_binario #(
    parameter int NUM_DIGITOS = 5,
    parameter int ANCHO_BIN   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     iniciar,
    input  logic [4*NUM_DIGITOS-1:0] bcd_entrada,
    output logic [ANCHO_BIN-1:0]     binario,
    output logic                     terminado,
    output logic                     ocupado,
    output logic                     desborde,
    output logic                     invalido
);

    localparam int ACC_W = 4 * NUM_DIGITOS;
    localparam int CNT_W = $clog2(NUM_DIGITOS + 1);
    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(NUM_DIGITOS - 1);

    typedef enum logic [1:0] {REPOSO, CONVERTIR, FIN} estado_t;

    estado_t              estado_q, estado_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [ACC_W-1:0]     desp_q, desp_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 inval_q, inval_d;
    logic [ANCHO_BIN-1:0] binario_q, binario_d;
    logic                 terminado_q, terminado_d;
    logic                 desborde_q, desborde_d;
    logic                 invalido_q, invalido_d;

    logic [NUM_DIGITOS-1:0] nibble_inval;
    logic                   excede;
    logic [ANCHO_BIN-1:0]   acc_trunc;
    logic [3:0]             digito;

    generate
        for (genvar gi = 0; gi < NUM_DIGITOS; gi++) begin : g_nibble
            assign nibble_inval[gi] = (bcd_entrada[4*gi +: 4] > 4'd9);
        end
        // 10^N < 16^N, so the accumulator never wraps; only the bits above ANCHO_BIN matter.
        if (ACC_W > ANCHO_BIN) begin : g_excede
            assign excede    = |acc_q[ACC_W-1:ANCHO_BIN];
            assign acc_trunc = acc_q[ANCHO_BIN-1:0];
        end else begin : g_sin_excede
            assign excede    = 1'b0;
            assign acc_trunc = ANCHO_BIN'(acc_q);
        end
    endgenerate

    assign digito = desp_q[ACC_W-1 -: 4];

    always_comb begin
        estado_d    = estado_q;
        acc_d       = acc_q;
        desp_d      = desp_q;
        cnt_d       = cnt_q;
        inval_d     = inval_q;
        binario_d   = binario_q;
        terminado_d = 1'b0;
        desborde_d  = desborde_q;
        invalido_d  = invalido_q;
        case (estado_q)
            REPOSO: begin
                if (iniciar) begin
                    desp_d   = bcd_entrada;
                    acc_d    = '0;
                    cnt_d    = '0;
                    inval_d  = |nibble_inval;
                    estado_d = CONVERTIR;
                end
            end
            CONVERTIR: begin
                acc_d  = (acc_q << 3) + (acc_q << 1) + ACC_W'(digito);
                desp_d = desp_q << 4;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == ULTIMO) begin
                    estado_d = FIN;
                end
            end
            FIN: begin
                terminado_d = 1'b1;
                estado_d    = REPOSO;
                if (inval_q) begin
                    binario_d  = '0;
                    invalido_d = 1'b1;
                    desborde_d = 1'b0;
                end else if (excede) begin
                    binario_d  = '1;
                    invalido_d = 1'b0;
                    desborde_d = 1'b1;
                end else begin
                    binario_d  = acc_trunc;
                    invalido_d = 1'b0;
                    desborde_d = 1'b0;
                end
            end
            default: estado_d = REPOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q    <= REPOSO;
            acc_q       <= '0;
            desp_q      <= '0;
            cnt_q       <= '0;
            inval_q     <= 1'b0;
            binario_q   <= '0;
            terminado_q <= 1'b0;
            desborde_q  <= 1'b0;
            invalido_q  <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            acc_q       <= acc_d;
            desp_q      <= desp_d;
            cnt_q       <= cnt_d;
            inval_q     <= inval_d;
            binario_q   <= binario_d;
            terminado_q <= terminado_d;
            desborde_q  <= desborde_d;
            invalido_q  <= invalido_d;
        end
    end

    assign binario   = binario_q;
    assign terminado = terminado_q;
    assign ocupado   = (estado_q != REPOSO);
    assign desborde  = desborde_q;
    assign invalido  = invalido_q;

endmodule

// File: tb/tb_bcd_a_binario.sv
// Bench for bcd_a_binario: cycle model of the handshake plus directed and random vectors.
module tb_bcd_a_binario;

    localparam int N = 5;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          iniciar;
    logic [4*N-1:0] bcd;
    logic [W-1:0]  binario;
    logic          terminado, ocupado, desborde, invalido;

    int tests  = 0;
    int errors = 0;

    bcd_a_binario #(.NUM_DIGITOS(N), .ANCHO_BIN(W)) dut (
        .clk(clk), .rst_n(rst_n), .iniciar(iniciar), .bcd_entrada(bcd),
        .binario(binario), .terminado(terminado), .ocupado(ocupado),
        .desborde(desborde), .invalido(invalido)
    );

    always #5 clk = ~clk;

    // Reference: {invalido, desborde, binario} from the decimal value of the digits.
    function automatic logic [W+1:0] ref_conv(input logic [4*N-1:0] b);
        int unsigned v = 0;
        logic        inv = 1'b0;
        for (int i = 0; i < N; i++) begin
            int unsigned d = b[4*i +: 4];
            if (d > 9) inv = 1'b1;
            v += d * (10 ** i);
        end
        if (inv)            return {1'b1, 1'b0, 16'h0000};
        else if (v > 65535) return {1'b0, 1'b1, 16'hFFFF};
        else                return {1'b0, 1'b0, v[W-1:0]};
    endfunction

    function automatic logic [4*N-1:0] to_bcd(input int unsigned v);
        logic [4*N-1:0] b = '0;
        for (int i = 0; i < N; i++) b[4*i +: 4] = 4'((v / (10 ** i)) % 10);
        return b;
    endfunction

    // Handshake model: busy for N+1 cycles after acceptance, then a one-cycle result pulse.
    int             m_busy = 0;
    logic           m_term = 1'b0;
    logic [W+1:0]   m_res  = '0;
    logic [W+1:0]   m_pend = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0;
            m_term <= 1'b0;
            m_res  <= '0;
        end else begin
            m_term <= 1'b0;
            if (m_busy == 0) begin
                if (iniciar) begin
                    m_busy <= N + 1;
                    m_pend <= ref_conv(bcd);
                end
            end else begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    m_term <= 1'b1;
                    m_res  <= m_pend;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic run(input logic [4*N-1:0] b, input logic [W-1:0] e_bin,
                       input logic e_des, input logic e_inv);
        int lat;
        @(negedge clk);
        bcd     = b;
        iniciar = 1'b1;
        @(posedge clk);
        #1 iniciar = 1'b0;
        lat = 0;
        while (!terminado && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        check("latency", lat, 6);
        check("binario", 32'(binario), 32'(e_bin));
        check("desborde", 32'(desborde), 32'(e_des));
        check("invalido", 32'(invalido), 32'(e_inv));
        $display("[TB] bcd=%h binario=%0d desborde=%b invalido=%b latency=%0d",
                 b, binario, desborde, invalido, lat);
    endtask

    initial begin
        int tcount;
        int t_first, t_second;
        rst_n   = 1'b0;
        iniciar = 1'b0;
        bcd     = '0;

        fork
            forever begin
                @(negedge clk);
                tests++;
                if ({terminado, ocupado, desborde, invalido, binario} !==
                    {m_term, (m_busy != 0), m_res[W], m_res[W+1], m_res[W-1:0]}) begin
                    errors++;
                    $display("[TB] FAIL cycle_model t=%0t: got term=%b ocu=%b des=%b inv=%b bin=%0d, expected term=%b ocu=%b des=%b inv=%b bin=%0d",
                             $time, terminado, ocupado, desborde, invalido, binario,
                             m_term, (m_busy != 0), m_res[W], m_res[W+1], m_res[W-1:0]);
                end
            end
        join_none

        #95;
        check("reset_state", 32'({binario, terminado, ocupado, desborde, invalido}), 32'd0);
        #5 rst_n = 1'b1;

        run(20'h00255, 16'd255, 1'b0, 1'b0);
        run(20'h65535, 16'hFFFF, 1'b0, 1'b0);
        run(20'h65536, 16'hFFFF, 1'b1, 1'b0);
        run(20'h99999, 16'hFFFF, 1'b1, 1'b0);
        run(20'h0012A, 16'h0000, 1'b0, 1'b1);
        run(20'h00000, 16'h0000, 1'b0, 1'b0);
        run(20'hA0001, 16'h0000, 1'b0, 1'b1);

        // Input change and iniciar during conversion are ignored; iniciar in the done cycle starts next.
        @(negedge clk);
        bcd     = 20'h01234;
        iniciar = 1'b1;
        @(posedge clk);
        #1 iniciar = 1'b0;
        tcount = 0;
        repeat (2) begin
            @(posedge clk);
            #1 if (terminado) tcount++;
        end
        bcd     = 20'h09999;
        iniciar = 1'b1;
        @(posedge clk);
        #1 iniciar = 1'b0;
        if (terminado) tcount++;
        repeat (3) begin
            @(posedge clk);
            #1 if (terminado) tcount++;
        end
        check("busy_terminado_count", tcount, 1);
        check("busy_terminado_now", 32'(terminado), 32'd1);
        check("busy_binario", 32'(binario), 32'd1234);
        $display("[TB] bcd=01234 (09999 ignored) binario=%0d terminado_count=%0d", binario, tcount);
        bcd     = 20'h00777;
        iniciar = 1'b1;
        @(posedge clk);
        #1 iniciar = 1'b0;
        check("restart_terminado_low", 32'(terminado), 32'd0);
        check("restart_ocupado", 32'(ocupado), 32'd1);
        tcount = 0;
        while (!terminado && tcount < 20) begin
            @(posedge clk);
            #1 tcount++;
        end
        check("restart_latency", tcount, 6);
        check("restart_binario", 32'(binario), 32'd777);
        $display("[TB] bcd=00777 binario=%0d latency=%0d", binario, tcount);

        // Continuous iniciar: one result every N+2 cycles.
        @(negedge clk);
        bcd     = 20'h00100;
        iniciar = 1'b1;
        t_first  = -1;
        t_second = -1;
        for (int c = 1; c <= 30 && t_second < 0; c++) begin
            @(posedge clk);
            #1 if (terminado) begin
                if (t_first < 0) t_first = c;
                else t_second = c;
            end
        end
        iniciar = 1'b0;
        check("back_to_back_period", t_second - t_first, N + 2);
        check("back_to_back_binario", 32'(binario), 32'd100);
        $display("[TB] back-to-back bcd=00100 period=%0d", t_second - t_first);
        repeat (10) @(posedge clk);

        // Reset in the middle of a conversion.
        @(negedge clk);
        bcd     = 20'h54321;
        iniciar = 1'b1;
        @(posedge clk);
        #1 iniciar = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'({binario, terminado, ocupado, desborde, invalido}), 32'd0);
        tcount = 0;
        repeat (3) begin
            @(posedge clk);
            #1 if (terminado) tcount++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1 if (terminado) tcount++;
        end
        check("abort_no_terminado", tcount, 0);
        $display("[TB] reset during bcd=54321: terminado_count=%0d", tcount);
        run(20'h00042, 16'd42, 1'b0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            int unsigned v;
            v = $urandom_range(0, 65535);
            run(to_bcd(v), v[W-1:0], 1'b0, 1'b0);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
